// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises the mp4 instruction-fetch and load/store ports onto one word-level memory port.
// Build option MEM_ARB_ROUND_ROBIN_EN alternates grants under contention; otherwise data always wins.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_read,
  input  logic [31:0] inst_addr,
  output logic        inst_resp,
  output logic [31:0] inst_rdata,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [3:0]  data_mbe,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_resp,
  output logic [31:0] data_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_mbe,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INST_BUSY = 2'd1,
    DATA_BUSY = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mbe_q, mbe_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic        inst_req_s;
  logic        data_req_s;
  logic        grant_data_s;

  assign inst_req_s = inst_read;
  assign data_req_s = data_read | data_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // last_grant_q: 1'b1 = data was granted last, 1'b0 = inst (reset value, so data wins first contention)
  logic last_grant_q, last_grant_d;

  // Contention goes to whichever port was not granted last
  always_comb begin
    if (inst_req_s && data_req_s) begin
      grant_data_s = ~last_grant_q;
    end else begin
      grant_data_s = data_req_s;
    end
  end
`else
  assign grant_data_s = data_req_s;
`endif

  // Next-state, latched transaction and response strobes
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mbe_d       = mbe_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    inst_resp   = 1'b0;
    data_resp   = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_data_s) begin
          state_d     = DATA_BUSY;
          addr_d      = data_addr;
          wdata_d     = data_wdata;
          mbe_d       = data_mbe;
          mem_write_d = data_write;  // read+write together is a write
          mem_read_d  = ~data_write;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_d = 1'b1;
`endif
        end else if (inst_req_s) begin
          state_d     = INST_BUSY;
          addr_d      = inst_addr;
          mbe_d       = 4'hF;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_d = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      INST_BUSY: begin
        if (mem_resp) begin
          inst_resp   = 1'b1;
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end else begin
          state_d = INST_BUSY;
        end
      end
      DATA_BUSY: begin
        if (mem_resp) begin
          data_resp   = 1'b1;
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end else begin
          state_d = DATA_BUSY;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // State and memory-port registers; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      mbe_q       <= 4'h0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mbe_q       <= mbe_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_mbe    = mbe_q;
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter directly downstream of the `mp4` core. Accepts the core's independent instruction-fetch port (`inst_*`) and load/store port (`data_*`), serialises them onto one word-level memory port (`mem_*`), and routes each response back to the port that issued it. Exactly one memory transaction is outstanding at any time.

## Interface
Parameters:
- none; all widths fixed at 32-bit address/data (`rv32i_word`).

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `inst_read` in 1: fetch request, held until `inst_resp`.
- `inst_addr` in 32: fetch address.
- `inst_resp` out 1: fetch complete, one-cycle pulse.
- `inst_rdata` out 32: fetch data, valid with `inst_resp`.
- `data_read` in 1: load request, held until `data_resp`.
- `data_write` in 1: store request, held until `data_resp`.
- `data_mbe` in 4: store byte enables.
- `data_addr` in 32: load/store address.
- `data_wdata` in 32: store data.
- `data_resp` out 1: load/store complete, one-cycle pulse.
- `data_rdata` out 32: load data, valid with `data_resp`.
- `mem_read` out 1: memory read, held until `mem_resp`.
- `mem_write` out 1: memory write, held until `mem_resp`.
- `mem_mbe` out 4: byte enables.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: write data.
- `mem_resp` in 1: memory transaction complete.
- `mem_rdata` in 32: read data, valid with `mem_resp`.

## Operation
- FSM states: `IDLE`, `INST_BUSY`, `DATA_BUSY`.
- `IDLE`: sample requests. Data request = `data_read | data_write`.
  - Only inst pending -> latch `inst_addr`, `mbe=4'hF`, type=read; go `INST_BUSY`.
  - Only data pending -> latch `data_addr`, `data_wdata`, `data_mbe`, type=write if `data_write` else read; go `DATA_BUSY`.
  - Both pending -> winner per Configuration; loser stays pending, untouched.
  - `data_read & data_write` both high -> treated as write.
- `*_BUSY`: `mem_read`/`mem_write`, `mem_addr`, `mem_wdata`, `mem_mbe` driven from latched registers only; requester input changes ignored.
- On `mem_resp` in `INST_BUSY`: `inst_resp=1`, `inst_rdata=mem_rdata` same cycle (combinational); next state `IDLE`. Likewise `DATA_BUSY` -> `data_resp`, `data_rdata`.
- `inst_rdata`/`data_rdata` pass `mem_rdata` through at all times; only `*_resp` qualify them.
- `mem_resp` while `IDLE` ignored: no `*_resp` generated.
- Requester contract: request sampled in `IDLE` on the cycle after its `*_resp` is a new request.

## Timing
- Reset (`rst=0` at edge): state `IDLE`; `mem_read=0`, `mem_write=0`, `mem_mbe=0`, `mem_addr=0`, `mem_wdata=0`; `inst_resp=0`, `data_resp=0`; priority register cleared to favour data.
- Reset mid-transaction: abandon transaction, drop `mem_*` strobes next cycle; in-flight `mem_resp` then arrives in `IDLE` and is ignored.
- Request seen in `IDLE` at cycle T -> `mem_read`/`mem_write` high from T+1.
- `mem_resp` at cycle N -> `*_resp` at N, `mem_*` strobes low at N+1 (`IDLE`), next grant earliest issue N+2.
- Minimum per-transaction occupancy: 2 cycles plus memory latency; back-to-back throughput 1 txn per (mem latency + 2) cycles.
- `inst_resp` and `data_resp` never high in the same cycle.
- `mem_read` and `mem_write` never high in the same cycle.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: 1-bit `last_grant` register; on simultaneous requests in `IDLE`, grant goes to the port not granted last; `last_grant` updates on every grant; reset value = inst, so first contention goes to data.
- Not defined: data always wins simultaneous contention (store commit and load completion never starved by fetch); no `last_grant` register.

## Test plan
- Reset then `inst_read=1`, `inst_addr=0x60`, memory latency 3 -> `mem_read` high cycles 1-4, `mem_addr=0x60`, `mem_mbe=4'hF`; `inst_resp` pulse with `inst_rdata=mem_rdata` on cycle 4 only.
- Store `data_write=1`, `data_addr=0x1004`, `data_mbe=4'b0011`, `data_wdata=0xDEADBEEF`; change `data_wdata` mid-transaction -> `mem_wdata` stays `0xDEADBEEF`, `mem_mbe=4'b0011`, single `data_resp`.
- `inst_read` and `data_read` raised same cycle, requests held until served -> without macro: data served first, inst second; with `MEM_ARB_ROUND_ROBIN_EN` and three contentions: data, inst, data.
- Drive `rst=0` during `DATA_BUSY`, then `mem_resp=1` one cycle after reset release -> `mem_*` strobes low after reset edge, no `data_resp` or `inst_resp` pulse.
- Both `data_read=1` and `data_write=1` at `0x200` -> `mem_write=1`, `mem_read=0` throughout.
- Random back-to-back mix of 1000 requests vs reference memory model -> every `*_resp` matches model data, no simultaneous resps, no dual strobes.
